// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment read-back path: active-low {a..g}
// patterns for hex digits and blank, plus the scan decoder FSM state type.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps an active-low {a..g} pattern back to its hex nibble.
// Purely combinational; no flow control.
module seg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_valid
);

    always_comb begin
        nibble   = 4'h0;
        is_blank = 1'b0;
        is_valid = 1'b1;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                is_blank = 1'b1;
                is_valid = 1'b0;
            end
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed active-low 7-seg bus.
// Latency: capture STABLE_CYCLES edges after a pattern is first sampled.
// No backpressure: the bus is sampled every cycle. Option: SSD_DP_CAPTURE_EN.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS-1:0]         an,
    input  logic [6:0]                    seg,
`ifdef SSD_DP_CAPTURE_EN
    input  logic                          dp,
    output logic [NUM_DIGITS-1:0]         dp_out,
`endif
    input  logic                          err_clr,
    output logic [4*NUM_DIGITS-1:0]       digits,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic                          new_digit,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          err
);

    localparam int IDXW = $clog2(NUM_DIGITS);
    localparam int CW   = $clog2(STABLE_CYCLES + 1);
`ifdef SSD_DP_CAPTURE_EN
    localparam int SW   = NUM_DIGITS + 8;
`else
    localparam int SW   = NUM_DIGITS + 7;
`endif

    logic [SW-1:0]         sample_in;
    logic [SW-1:0]         smp;
    logic [NUM_DIGITS-1:0] smp_an;
    logic [6:0]            smp_seg;
    logic [CW-1:0]         count;
    state_t                state;

`ifdef SSD_DP_CAPTURE_EN
    assign sample_in = {an, seg, dp};
`else
    assign sample_in = {an, seg};
`endif
    assign smp_an  = smp[SW-1 -: NUM_DIGITS];
    assign smp_seg = smp[SW-NUM_DIGITS-1 -: 7];

    logic [3:0] dec_nibble;
    logic       dec_blank;
    logic       dec_valid;

    seg_pattern_decode u_decode (
        .seg      (smp_seg),
        .nibble   (dec_nibble),
        .is_blank (dec_blank),
        .is_valid (dec_valid)
    );

    logic            changed;
    logic            single_in;
    logic            capture;
    logic [IDXW-1:0] cap_idx;

    assign changed   = (sample_in != smp);
    assign single_in = ($countones(~an) == 1);
    // A capture needs the pattern to survive one more identical edge.
    assign capture   = (state == SETTLE) && !changed &&
                       (count == CW'(STABLE_CYCLES - 1));

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!smp_an[i]) cap_idx = IDXW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp         <= '1;
            state       <= IDLE;
            count       <= '0;
            digits      <= '0;
            digit_valid <= '0;
            new_digit   <= 1'b0;
            digit_idx   <= '0;
            err         <= 1'b0;
`ifdef SSD_DP_CAPTURE_EN
            dp_out      <= '0;
`endif
        end else begin
            smp       <= sample_in;
            new_digit <= 1'b0;
            if (err_clr) err <= 1'b0;
            if (changed) begin
                count <= '0;
                state <= single_in ? SETTLE : IDLE;
            end else begin
                if (state != IDLE && count != CW'(STABLE_CYCLES)) count <= count + 1'b1;
                if (capture) begin
                    state     <= HOLD;
                    new_digit <= 1'b1;
                    digit_idx <= cap_idx;
                    if (dec_valid) begin
                        digits[4*cap_idx +: 4] <= dec_nibble;
                        digit_valid[cap_idx]   <= 1'b1;
`ifdef SSD_DP_CAPTURE_EN
                        dp_out[cap_idx]        <= ~smp[0];
`endif
                    end else begin
                        digit_valid[cap_idx] <= 1'b0;
                        // Error set wins over a simultaneous clear.
                        if (!dec_blank) err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_sevenseg_scan_decoder;

    localparam int ND     = 4;
    localparam int STABLE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          err_clr;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic          new_digit;
    logic [1:0]    digit_idx;
    logic          err;
`ifdef SSD_DP_CAPTURE_EN
    logic [ND-1:0] dp_out;
`endif

    sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
`ifdef SSD_DP_CAPTURE_EN
        .dp          (1'b1),
        .dp_out      (dp_out),
`endif
        .err_clr     (err_clr),
        .digits      (digits),
        .digit_valid (digit_valid),
        .new_digit   (new_digit),
        .digit_idx   (digit_idx),
        .err         (err)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Reference model: a capture happens when the same bus value has been
    // seen on STABLE+1 consecutive edges and exactly one anode is low.
    logic [ND+6:0] m_last;
    logic [ND+6:0] cur;
    int            m_run;
    logic [3:0]    m_nib [ND];
    logic [ND-1:0] m_valid;
    logic          m_new;
    int            m_idx;
    logic          m_err;
    int            d;
    int            pos;

    function automatic int lookup(input logic [6:0] s);
        int r;
        r = (s == 7'h7F) ? -1 : -2;
        for (int k = 0; k < 16; k++) if (tbl[k] == s) r = k;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_last  = '1;
            m_run   = 0;
            m_valid = '0;
            m_new   = 1'b0;
            m_idx   = 0;
            m_err   = 1'b0;
            for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
        end else begin
            cur   = {an, seg};
            m_new = 1'b0;
            if (cur != m_last) m_run = 0;
            else if (m_run <= STABLE) m_run++;
            m_last = cur;
            if (err_clr) m_err = 1'b0;
            if (m_run == STABLE && $countones(~an) == 1) begin
                pos = 0;
                for (int i = 0; i < ND; i++) if (!an[i]) pos = i;
                d = lookup(seg);
                m_new = 1'b1;
                m_idx = pos;
                if (d >= 0) begin
                    m_nib[pos]   = d[3:0];
                    m_valid[pos] = 1'b1;
                end else begin
                    m_valid[pos] = 1'b0;
                    if (d == -2) m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        tests += 5;
        if (digits !== {m_nib[3], m_nib[2], m_nib[1], m_nib[0]}) begin
            fails++;
            $display("FAIL model_digits t=%0t got %h exp %h", $time, digits,
                     {m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
        end
        if (digit_valid !== m_valid) begin
            fails++;
            $display("FAIL model_valid t=%0t got %b exp %b", $time, digit_valid, m_valid);
        end
        if (new_digit !== m_new) begin
            fails++;
            $display("FAIL model_new t=%0t got %b exp %b", $time, new_digit, m_new);
        end
        if (digit_idx !== m_idx[1:0]) begin
            fails++;
            $display("FAIL model_idx t=%0t got %0d exp %0d", $time, digit_idx, m_idx);
        end
        if (err !== m_err) begin
            fails++;
            $display("FAIL model_err t=%0t got %b exp %b", $time, err, m_err);
        end
        if (new_digit === 1'b1) pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    logic [3:0] two_low [5] = '{4'b1100, 4'b0101, 4'b1010, 4'b0011, 4'b0000};
    int r;
    int r2;

    initial begin
        // Reset with a valid pattern already on the bus.
        reset = 1'b1; an = 4'b1110; seg = 7'b0000001; err_clr = 1'b0;
        step(3);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_flags", {29'h0, new_digit, err, digit_idx == 2'd0}, 32'h1);
        pulses = 0;
        reset = 1'b0;
        step(5);
        chk("t1_digit0", 32'(digits[3:0]), 32'h0);
        chk("t1_valid", 32'(digit_valid), 32'b0001);
        chk("t1_new", 32'(new_digit), 32'h1);
        step(3);
        chk("t1_pulses", pulses, 1);

        // Pattern dropped one edge short of capture, then held long enough.
        pulses = 0;
        an = 4'b1011; seg = tbl[10];
        step(4);
        chk("t2_short_new", 32'(new_digit), 32'h0);
        an = 4'b1111;
        step(1);
        an = 4'b1011;
        step(5);
        chk("t2_digit2", 32'(digits[11:8]), 32'hA);
        chk("t2_idx", 32'(digit_idx), 32'd2);
        step(1);
        chk("t2_pulses", pulses, 1);

        // Two full scans of 1,2,B,F.
        for (int s = 0; s < 2; s++) begin
            pulses = 0;
            an = 4'b1110; seg = tbl[1];  step(8);
            an = 4'b1101; seg = tbl[2];  step(8);
            an = 4'b1011; seg = tbl[11]; step(8);
            an = 4'b0111; seg = tbl[15]; step(8);
            chk("t3_pulses", pulses, 4);
        end
        chk("t3_digits", 32'(digits), 32'hFB21);
        chk("t3_valid", 32'(digit_valid), 32'b1111);

        // Unknown pattern, clear, then clear colliding with a new error.
        an = 4'b1101; seg = 7'b1111110;
        step(6);
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_valid", 32'(digit_valid), 32'b1101);
        an = 4'b1111; err_clr = 1'b1;
        step(1);
        chk("t4_clr", 32'(err), 32'h0);
        an = 4'b1110; seg = 7'b1111110;
        step(5);
        chk("t4_set_wins", 32'(err), 32'h1);
        err_clr = 1'b0;
        pulses = 0;
        an = 4'b0111; seg = 7'b1111111;
        step(5);
        chk("t4_blank_new", 32'(new_digit), 32'h1);
        chk("t4_blank_digit", 32'(digits[15:12]), 32'hF);

        // Two anodes low: never captures.
        step(1);
        pulses = 0;
        an = 4'b1100; seg = tbl[5];
        step(20);
        chk("t5_pulses", pulses, 0);
        chk("t5_digits", 32'(digits), 32'hFB21);
        chk("t5_valid", 32'(digit_valid), 32'b0100);

        // Reset in the middle of settling.
        an = 4'b1110; seg = tbl[7];
        step(3);
        #2 reset = 1'b1;
        #1;
        chk("t6_clear_digits", 32'(digits), 32'h0);
        chk("t6_clear_valid", 32'(digit_valid), 32'h0);
        step(1);
        reset = 1'b0;
        step(4);
        chk("t6_no_early", 32'(new_digit), 32'h0);
        step(1);
        chk("t6_capture", 32'(new_digit), 32'h1);
        chk("t6_digit0", 32'(digits[3:0]), 32'h7);
        chk("t6_valid", 32'(digit_valid), 32'b0001);

        // Random bus traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6) an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 7) an = 4'b1111;
            else an = two_low[$urandom_range(0, 4)];
            r2 = $urandom_range(0, 9);
            if (r2 < 7) seg = tbl[$urandom_range(0, 15)];
            else if (r2 < 8) seg = 7'h7F;
            else seg = 7'($urandom);
            err_clr = ($urandom_range(0, 9) == 0);
            step($urandom_range(1, 8));
        end
        err_clr = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
